sa_pe_dot: RTL and testbench

SA_PE_DOT -- requirements
Module: sa_pe_dot

---
 rtl/sa_pe_dot.sv | 144 ++++++++++++++
 tb/tb_sa_pe_dot.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sa_pe_dot.sv
// Systolic-array PE: forwards operands to neighbours and accumulates K signed products per dot product.
// Optional macro SA_PE_SAT_EN selects saturating accumulation with a sticky sat_flag (default: wrap).
module sa_pe_dot #(
   parameter int WIDTH = 8,
   parameter int ACC   = 32,
   parameter int K     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] a_in,
   input  logic signed [WIDTH-1:0] b_in,
   output logic signed [WIDTH-1:0] a_out,
   output logic signed [WIDTH-1:0] b_out,
   output logic                    fwd_valid,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic signed [ACC-1:0]   res_data,
   output logic                    sat_flag
);

   localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

   typedef enum logic {IDLE, ACCUM} phase_t;

   phase_t                  state_p1, state_d;
   logic [CNT_W-1:0]        cnt_p1, cnt_d, cnt_eff;
   logic signed [ACC-1:0]   acc_p1, acc_d, acc_eff;
   logic signed [ACC-1:0]   res_p1, res_d;
   logic signed [2*WIDTH-1:0] mul_p0;
   logic signed [ACC-1:0]   prod_p0, sum_p0;
   logic signed [WIDTH-1:0] a_p1, b_p1;
   logic                    vld_p1, rv_p1, rv_d;
   logic                    accept;

`ifdef SA_PE_SAT_EN
   localparam logic signed [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
   localparam logic signed [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};

   logic signed [ACC:0] sum_ext_p0;
   logic                ovf_p0;
   logic                sat_p1;

   function automatic logic signed [ACC:0] add_ext(input logic signed [ACC-1:0] x,
                                                   input logic signed [ACC-1:0] y);
      return $signed({x[ACC-1], x}) + $signed({y[ACC-1], y});
   endfunction

   // One guard bit above the accumulator; disagreement with the sign bit means overflow.
   function automatic logic signed [ACC-1:0] sat_acc(input logic signed [ACC:0] s);
      if (s[ACC] != s[ACC-1])
         return s[ACC] ? ACC_MIN : ACC_MAX;
      return s[ACC-1:0];
   endfunction
`endif

   // Stage p0: product, sum and next-state decode
   assign in_ready = !((cnt_p1 == LAST) && rv_p1 && !res_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      mul_p0  = a_in * b_in;
      prod_p0 = ACC'(mul_p0);
      acc_eff = (clear || state_p1 == IDLE) ? '0 : acc_p1;
      cnt_eff = clear ? '0 : cnt_p1;
`ifdef SA_PE_SAT_EN
      sum_ext_p0 = add_ext(acc_eff, prod_p0);
      sum_p0     = sat_acc(sum_ext_p0);
      ovf_p0     = sum_ext_p0[ACC] ^ sum_ext_p0[ACC-1];
`else
      sum_p0 = acc_eff + prod_p0;
`endif
   end

   always_comb begin
      acc_d = acc_p1;
      cnt_d = cnt_p1;
      res_d = res_p1;
      rv_d  = rv_p1 && !res_ready;
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end
      if (accept) begin
         if (cnt_eff == LAST) begin
            res_d = sum_p0;
            rv_d  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum_p0;
            cnt_d = cnt_eff + CNT_W'(1);
         end
      end
      state_d = (cnt_d == '0) ? IDLE : ACCUM;
   end

   // Stage p1: registered accumulator, result and forwarded operands
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1 <= IDLE;
         cnt_p1   <= '0;
         acc_p1   <= '0;
         res_p1   <= '0;
         rv_p1    <= 1'b0;
         a_p1     <= '0;
         b_p1     <= '0;
         vld_p1   <= 1'b0;
      end else begin
         state_p1 <= state_d;
         cnt_p1   <= cnt_d;
         acc_p1   <= acc_d;
         res_p1   <= res_d;
         rv_p1    <= rv_d;
         vld_p1   <= accept;
         if (accept) begin
            a_p1 <= a_in;
            b_p1 <= b_in;
         end
      end
   end

`ifdef SA_PE_SAT_EN
   always_ff @(posedge clk) begin
      if (rst)
         sat_p1 <= 1'b0;
      else if (accept && ovf_p0)
         sat_p1 <= 1'b1;
   end
   assign sat_flag = sat_p1;
`else
   assign sat_flag = 1'b0;
`endif

   assign a_out     = a_p1;
   assign b_out     = b_p1;
   assign fwd_valid = vld_p1;
   assign res_valid = rv_p1;
   assign res_data  = res_p1;

endmodule

// File: tb/tb_sa_pe_dot.sv
// Scoreboard bench for sa_pe_dot: default PE against a cycle model, plus an ACC=16 PE for overflow.
module tb_sa_pe_dot;

   localparam int K = 4;

   logic clk = 1'b0;
   logic rst, clear, in_valid, in_valid16, res_ready;
   logic signed [7:0] a, b;

   logic              in_ready, fwd_valid, res_valid, sat_flag;
   logic signed [7:0] a_out, b_out;
   logic signed [31:0] res_data;

   logic              in_ready16, fwd16, rv16, sat16;
   logic signed [7:0] a_out16, b_out16;
   logic signed [15:0] rd16;

   int n_chk = 0;
   int n_pass = 0;

   int                m_cnt = 0;
   logic signed [31:0] m_acc = 0;
   logic              m_rv = 1'b0;
   logic              m_fv = 1'b0;
   logic signed [7:0] m_a = 0;
   logic signed [7:0] m_b = 0;
   logic signed [31:0] q[$];

   always #5 clk = ~clk;

   sa_pe_dot #(.WIDTH(8), .ACC(32), .K(K)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a), .b_in(b), .a_out(a_out), .b_out(b_out), .fwd_valid(fwd_valid),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .sat_flag(sat_flag)
   );

   sa_pe_dot #(.WIDTH(8), .ACC(16), .K(4)) dut16 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid16), .in_ready(in_ready16),
      .a_in(a), .b_in(b), .a_out(a_out16), .b_out(b_out16), .fwd_valid(fwd16),
      .res_valid(rv16), .res_ready(res_ready), .res_data(rd16), .sat_flag(sat16)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Check outputs at the falling edge, then advance the model across the rising edge.
   task automatic cycle();
      logic              m_ready;
      logic signed [31:0] p, eacc;
      int                ecnt;
      @(negedge clk);
      m_ready = !(m_cnt == K-1 && m_rv && !res_ready);
      chk("in_ready", in_ready, m_ready);
      chk("res_valid", res_valid, m_rv);
      if (m_rv && q.size() > 0) chk("res_data", res_data, q[0]);
      chk("fwd_valid", fwd_valid, m_fv);
      chk("a_out", a_out, m_a);
      chk("b_out", b_out, m_b);
      chk("sat_flag", sat_flag, 0);
      if (rst) begin
         m_cnt = 0; m_acc = 0; m_rv = 0; m_fv = 0; m_a = 0; m_b = 0;
         q.delete();
      end else begin
         if (m_rv && res_ready) begin
            void'(q.pop_front());
            m_rv = 1'b0;
         end
         eacc = clear ? 0 : m_acc;
         ecnt = clear ? 0 : m_cnt;
         if (clear) begin
            m_acc = 0;
            m_cnt = 0;
         end
         m_fv = in_valid && m_ready;
         if (m_fv) begin
            m_a = a;
            m_b = b;
            p = a * b;
            if (ecnt == K-1) begin
               q.push_back(eacc + p);
               m_rv = 1'b1;
               m_acc = 0;
               m_cnt = 0;
            end else begin
               m_acc = eacc + p;
               m_cnt = ecnt + 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beats(input logic signed [7:0] av, input logic signed [7:0] bv, input int n);
      in_valid = 1'b1;
      a = av;
      b = bv;
      repeat (n) cycle();
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0; res_ready = 1'b1;
      a = 0; b = 0;
      repeat (3) cycle();
      rst = 1'b0;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_fwd", fwd_valid, 0);
      chk("rst_a_out", a_out, 0);
      chk("rst_sat", sat_flag, 0);

      // Basic dot product with forwarding
      in_valid = 1'b1; a = 3; b = 4;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("fwd_a3", a_out, 3);
         chk("fwd_b4", b_out, 4);
         chk("fwd_v", fwd_valid, 1);
      end
      chk("dot48_valid", res_valid, 1);
      chk("dot48", res_data, 48);
      in_valid = 1'b0;
      cycle();
      chk("fwd_idle", fwd_valid, 0);

      // Signed extremes, back-to-back dot products
      beats(-128, -128, 4);
      chk("dot65536", res_data, 65536);
      beats(-5, 7, 4);
      chk("dot_neg140", res_data, -140);
      in_valid = 1'b0;
      cycle();

      // Backpressure on the result port
      res_ready = 1'b0;
      beats(3, 4, 7);
      chk("stall_ready", in_ready, 0);
      chk("held48", res_data, 48);
      repeat (2) cycle();
      chk("still_held48", res_data, 48);
      res_ready = 1'b1;
      cycle();
      chk("second_valid", res_valid, 1);
      chk("second48", res_data, 48);
      in_valid = 1'b0;
      cycle();
      chk("drained", res_valid, 0);

      // Clear alone, then clear together with an accept
      beats(3, 4, 2);
      in_valid = 1'b0; clear = 1'b1;
      cycle();
      clear = 1'b0;
      beats(1, 1, 4);
      chk("clear_dot4", res_data, 4);
      beats(3, 4, 2);
      clear = 1'b1;
      beats(2, 2, 1);
      clear = 1'b0;
      beats(1, 1, 3);
      chk("clear_acc_dot7", res_data, 7);
      in_valid = 1'b0;
      cycle();

      // Reset mid dot product with a pending result
      res_ready = 1'b0;
      beats(1, 1, 6);
      in_valid = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst2_res_valid", res_valid, 0);
      chk("rst2_res_data", res_data, 0);
      chk("rst2_a_out", a_out, 0);
      chk("rst2_b_out", b_out, 0);
      chk("rst2_fwd", fwd_valid, 0);
      res_ready = 1'b1;
      beats(1, 2, 4);
      chk("post_rst_dot8", res_data, 8);
      in_valid = 1'b0;
      cycle();

      // Narrow accumulator overflow on the ACC=16 instance
      in_valid16 = 1'b1; a = 127; b = 127;
      repeat (4) cycle();
      in_valid16 = 1'b0;
      chk("acc16_valid", rv16, 1);
`ifdef SA_PE_SAT_EN
      chk("acc16_sat", rd16, 32767);
      chk("acc16_flag", sat16, 1);
`else
      chk("acc16_wrap", rd16, -1020);
      chk("acc16_flag", sat16, 0);
`endif
      cycle();

      // Random traffic against the model
      for (int i = 0; i < 120; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         res_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 15) == 0);
         a = 8'($urandom);
         b = 8'($urandom);
         cycle();
      end
      in_valid = 1'b0; clear = 1'b0; res_ready = 1'b1;
      repeat (3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
